prio_encoder_rr: RTL and testbench

//   Parametrised, registered N-input priority encoder with valid/ready handshake on both sides.

---
 rtl/prio_enc_pkg.sv | 42 ++++
 rtl/prio_encoder_rr_scan.sv | 62 ++++++
 rtl/prio_encoder_rr.sv | 117 +++++++++++
 tb/tb_prio_encoder_rr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// ---------------------------------------------------------------------------
// prio_enc_pkg
//   Shared definitions for the prio_encoder_rr arbiter front-end.
//   - MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   - out_state_e          : EMPTY/FULL state of the output register.
//   - clog2()              : index width helper (never returns less than 1).
//   - decode()             : index -> one-hot vector, used for the grant output.
// ---------------------------------------------------------------------------
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest request vector the encoder is built for.
    localparam int MAX_N = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Ceiling log2; a single-bit index is the minimum so N=2 still gets W=1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // One-hot decode of an index into a MAX_N-wide vector; callers truncate.
    function automatic logic [MAX_N-1:0] decode(input int index);
        logic [MAX_N-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_scan.sv
// ---------------------------------------------------------------------------
// prio_scan
//   Combinational priority scan over an N-bit request vector.
//   Ports:
//     req   in  N  request bits
//     start in  W  round-robin start position (ignored in fixed mode)
//     mode  in  1  MODE_FIXED: highest set bit wins
//                  MODE_RR   : first set bit scanning upward from start, wrapping
//     idx   out W  winning index (0 when no bit is set)
//     none  out 1  request vector is all-zero
// ---------------------------------------------------------------------------
module prio_scan
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         none
);

    // Rotated view of the request vector: rot[k] is the request at position
    // (start + k) mod N, so the round-robin winner is the lowest set bit of rot.
    logic [N-1:0] rot;
    logic [W-1:0] pos [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        // start < N and gi < N, so the sum stays below 2N and fits in W+1 bits;
        // one conditional subtract is enough for the wrap.
        logic [W:0] sum;
        assign sum     = {1'b0, start} + (W+1)'(gi);
        assign pos[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
        assign rot[gi] = req[pos[gi]];
    end

    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_idx;

    always_comb begin
        fixed_idx = '0;
        rr_idx    = '0;
        // Ascending loop: the last hit is the highest set bit.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_idx = W'(i);
            end
        end
        // Descending loop: the last hit is the lowest set bit of the rotated view.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_idx = pos[i];
            end
        end
    end

    assign none = ~|req;
    assign idx  = (mode == MODE_RR) ? rr_idx : fixed_idx;

endmodule

// File: rtl/prio_encoder_rr.sv
// ---------------------------------------------------------------------------
// prio_encoder_rr
//   Registered N-input priority encoder / arbiter front-end with valid/ready
//   handshakes on both sides. Fixed-priority (MSB wins) or round-robin mode,
//   chosen per accepted vector.
//   Optional feature macro: PRIO_ONEHOT_EN adds the registered one-hot grant.
//   Ports:
//     clk        in   1  rising-edge clock
//     rst_n      in   1  asynchronous active-low reset
//     req_valid  in   1  request vector valid
//     req_ready  out  1  a request vector can be accepted this cycle
//     req        in   N  request bits (bit i = source i requesting)
//     mode       in   1  MODE_FIXED / MODE_RR, sampled on accept
//     out_valid  out  1  result valid
//     out_ready  in   1  consumer takes the result
//     idx        out  W  winning index
//     none       out  1  accepted vector was all-zero (idx = 0)
//     onehot     out  N  1<<idx, 0 when none (PRIO_ONEHOT_EN only)
// ---------------------------------------------------------------------------
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic         none
`ifdef PRIO_ONEHOT_EN
   ,output logic [N-1:0] onehot
`endif
);

    out_state_e   state_reg, state_next;
    logic         accept;
    logic [W-1:0] scan_idx;
    logic         scan_none;
    logic [W-1:0] idx_reg;
    logic         none_reg;
    logic [W-1:0] rr_ptr_reg, rr_ptr_next;

    prio_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .req   (req),
        .start (rr_ptr_reg),
        .mode  (mode),
        .idx   (scan_idx),
        .none  (scan_none)
    );

    // Ready passes straight through while the held result is being drained,
    // which allows a new vector every cycle without a bubble.
    assign out_valid = (state_reg == ST_FULL);
    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // The pointer only moves past a real round-robin winner; zero vectors and
    // fixed-mode grants leave fairness state untouched.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept && (mode == MODE_RR) && !scan_none) begin
            rr_ptr_next = (scan_idx == W'(N - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_EMPTY;
            idx_reg    <= '0;
            none_reg   <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (accept) begin
                idx_reg  <= scan_none ? '0 : scan_idx;
                none_reg <= scan_none;
            end
        end
    end

    assign idx  = idx_reg;
    assign none = none_reg;

`ifdef PRIO_ONEHOT_EN
    logic [N-1:0] onehot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_reg <= '0;
        end else if (accept) begin
            onehot_reg <= scan_none ? '0 : N'(decode(int'(scan_idx)));
        end
    end

    assign onehot = onehot_reg;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// ---------------------------------------------------------------------------
// tb_prio_encoder_rr
//   Directed and random stimulus for prio_encoder_rr at N=8 and N=5.
//   Build with and without +define+PRIO_ONEHOT_EN.
// ---------------------------------------------------------------------------
module tb_prio_encoder_rr;
    import prio_enc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N = 8 instance
    logic       req_valid8 = 1'b0;
    logic       req_ready8;
    logic [7:0] req8       = '0;
    logic       mode8      = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [2:0] idx8;
    logic       none8;
`ifdef PRIO_ONEHOT_EN
    logic [7:0] onehot8;
`endif

    // N = 5 instance
    logic       req_valid5 = 1'b0;
    logic       req_ready5;
    logic [4:0] req5       = '0;
    logic       mode5      = 1'b0;
    logic       out_valid5;
    logic       out_ready5 = 1'b0;
    logic [2:0] idx5;
    logic       none5;
`ifdef PRIO_ONEHOT_EN
    logic [4:0] onehot5;
`endif

    prio_encoder_rr #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid8),
        .req_ready (req_ready8),
        .req       (req8),
        .mode      (mode8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .idx       (idx8),
        .none      (none8)
`ifdef PRIO_ONEHOT_EN
       ,.onehot    (onehot8)
`endif
    );

    prio_encoder_rr #(.N(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid5),
        .req_ready (req_ready5),
        .req       (req5),
        .mode      (mode5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .idx       (idx5),
        .none      (none5)
`ifdef PRIO_ONEHOT_EN
       ,.onehot    (onehot5)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: occupancy, held result and round-robin pointer.
    bit m8_full, m8_none, m5_full, m5_none;
    int m8_idx, m8_ptr, m5_idx, m5_ptr;

    // Winner of vector r of width n: -1 when empty. Fixed mode uses floor(log2(r));
    // round-robin rotates r right by ptr and isolates the lowest set bit.
    function automatic int ref_pick(bit [63:0] r, int n, bit m, int ptr);
        bit [63:0] mask, rot, low;
        if (r == 0) return -1;
        if (m == MODE_FIXED) return $clog2(r + 64'd1) - 1;
        mask = (64'd1 << n) - 64'd1;
        rot  = ((r >> ptr) | (r << (n - ptr))) & mask;
        low  = rot & (~rot + 64'd1);
        return (ptr + $clog2(low)) % n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid8", {63'd0, out_valid8}, {63'd0, m8_full});
        chk("idx8",   {61'd0, idx8},       64'(m8_idx));
        chk("none8",  {63'd0, none8},      {63'd0, m8_none});
        chk("ready8", {63'd0, req_ready8}, {63'd0, (!m8_full || out_ready8)});
        chk("valid5", {63'd0, out_valid5}, {63'd0, m5_full});
        chk("idx5",   {61'd0, idx5},       64'(m5_idx));
        chk("none5",  {63'd0, none5},      {63'd0, m5_none});
        chk("ready5", {63'd0, req_ready5}, {63'd0, (!m5_full || out_ready5)});
`ifdef PRIO_ONEHOT_EN
        chk("onehot8", {56'd0, onehot8}, m8_none ? 64'd0 : (64'd1 << m8_idx));
        chk("onehot5", {59'd0, onehot5}, m5_none ? 64'd0 : (64'd1 << m5_idx));
`endif
    endtask

    task automatic model_reset();
        m8_full = 0; m8_none = 0; m8_idx = 0; m8_ptr = 0;
        m5_full = 0; m5_none = 0; m5_idx = 0; m5_ptr = 0;
    endtask

    // One clock: predict from the inputs present at the edge, then check.
    task automatic tick();
        bit a8, a5;
        int p8, p5;
        a8 = rst_n && req_valid8 && (!m8_full || out_ready8);
        a5 = rst_n && req_valid5 && (!m5_full || out_ready5);
        p8 = ref_pick(64'(req8), 8, mode8, m8_ptr);
        p5 = ref_pick(64'(req5), 5, mode5, m5_ptr);
        @(posedge clk);
        #1;
        if (a8) begin
            m8_full = 1;
            m8_none = (p8 < 0);
            m8_idx  = (p8 < 0) ? 0 : p8;
            if (p8 >= 0 && mode8 == MODE_RR) m8_ptr = (p8 + 1) % 8;
        end else if (out_ready8) begin
            m8_full = 0;
        end
        if (a5) begin
            m5_full = 1;
            m5_none = (p5 < 0);
            m5_idx  = (p5 < 0) ? 0 : p5;
            if (p5 >= 0 && mode5 == MODE_RR) m5_ptr = (p5 + 1) % 5;
        end else if (out_ready5) begin
            m5_full = 0;
        end
        check_all();
        $display("t=%0t n8: v=%0b acc=%0b req=%02h mode=%0b -> idx=%0d none=%0b | n5: acc=%0b req=%02h -> idx=%0d none=%0b",
                 $time, out_valid8, a8, req8, mode8, idx8, none8, a5, req5, idx5, none5);
    endtask

    initial begin
        model_reset();

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;

        // Fixed priority
        mode8 = MODE_FIXED; out_ready8 = 1; req_valid8 = 1; req8 = 8'b0010_0110;
        tick();
        chk("t2_idx5", {61'd0, idx8}, 64'd5);
        chk("t2_none", {63'd0, none8}, 64'd0);
`ifdef PRIO_ONEHOT_EN
        chk("t2_onehot", {56'd0, onehot8}, 64'h20);
`endif
        req8 = 8'h01;
        tick();
        chk("t2_idx0", {61'd0, idx8}, 64'd0);

        // Round robin with all requests, wrap at 7
        mode8 = MODE_RR; req8 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_rr_seq", {61'd0, idx8}, 64'(i % 8));
        end
        for (int i = 2; i < 8; i++) begin
            tick();
            chk("t3_rr_seq2", {61'd0, idx8}, 64'(i));
        end
        req8 = 8'h81;
        tick();
        chk("t3_81_first", {61'd0, idx8}, 64'd0);
        tick();
        chk("t3_81_second", {61'd0, idx8}, 64'd7);

        // Backpressure then back-to-back reload
        mode8 = MODE_FIXED; req8 = 8'h08;
        tick();
        chk("t4_idx3", {61'd0, idx8}, 64'd3);
        out_ready8 = 0; req8 = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_idx", {61'd0, idx8}, 64'd3);
            chk("t4_hold_ready", {63'd0, req_ready8}, 64'd0);
        end
        out_ready8 = 1; req8 = 8'h40;
        #1;
        chk("t4_passthru_ready", {63'd0, req_ready8}, 64'd1);
        tick();
        chk("t4_b2b_valid", {63'd0, out_valid8}, 64'd1);
        chk("t4_b2b_idx", {61'd0, idx8}, 64'd6);

        // Zero vector leaves pointer alone
        mode8 = MODE_RR; req8 = 8'h04;
        tick();
        chk("t5_rr_idx2", {61'd0, idx8}, 64'd2);
        req8 = 8'h00;
        tick();
        chk("t5_zero_valid", {63'd0, out_valid8}, 64'd1);
        chk("t5_zero_none", {63'd0, none8}, 64'd1);
        chk("t5_zero_idx", {61'd0, idx8}, 64'd0);
`ifdef PRIO_ONEHOT_EN
        chk("t5_zero_onehot", {56'd0, onehot8}, 64'd0);
`endif
        req8 = 8'hFF;
        tick();
        chk("t5_ptr_kept", {61'd0, idx8}, 64'd3);
        req_valid8 = 0;
        tick();

        // Mode switch on N=5
        req_valid5 = 1; out_ready5 = 1; mode5 = MODE_RR; req5 = 5'b10000;
        tick();
        chk("t6_rr_idx4", {61'd0, idx5}, 64'd4);
        mode5 = MODE_FIXED; req5 = 5'b10011;
        tick();
        chk("t6_fixed_idx4", {61'd0, idx5}, 64'd4);
        mode5 = MODE_RR;
        tick();
        chk("t6_rr_wrap_idx0", {61'd0, idx5}, 64'd0);
        req_valid5 = 0;
        tick();

        // Asynchronous reset while FULL
        mode8 = MODE_FIXED; req_valid8 = 1; out_ready8 = 0; req8 = 8'h10;
        tick();
        chk("t1_full_before", {63'd0, out_valid8}, 64'd1);
        #2;
        rst_n = 1'b0;
        req_valid8 = 0;
        #1;
        model_reset();
        chk("t1_async_valid", {63'd0, out_valid8}, 64'd0);
        chk("t1_async_idx", {61'd0, idx8}, 64'd0);
        chk("t1_async_none", {63'd0, none8}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t1_ready_after", {63'd0, req_ready8}, 64'd1);

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            req_valid8 = ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 2) != 0);
            mode8      = 1'($urandom_range(0, 1));
            req8       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            req_valid5 = ($urandom_range(0, 3) != 0);
            out_ready5 = ($urandom_range(0, 2) != 0);
            mode5      = 1'($urandom_range(0, 1));
            req5       = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
